// File: rtl/adc_link_master.sv
// adc_link_master
// Host-side sequencer for the ADC serial bridge. Each transaction shifts the
// 32-bit config word LSB-first on link_dat_o. It then pulses link_load_o for
// one bit period so the bridge commits the config and captures a new result.
// During the same shift it collects the 20-bit framed result that the bridge
// captured on the previous load.
//
// Parameters
//   DIV         half-period of link_clk_o in clk cycles (1..255)
// Ports
//   clk, rst_n  system clock, async active-low reset
//   start       request a transaction (sampled in IDLE only)
//   cont        auto-restart from IDLE (back-to-back transactions)
//   cfg1_i      config link bits 0..15, latched on start
//   cfg2_i      config link bits 16..31, latched on start
//   busy        transaction in progress
//   res_o       last received result (frame bits 17:2)
//   res_valid   one-cycle pulse when res_o / frame_err update
//   frame_err   framing markers wrong for the current res_o
//   link_clk_o  link clock; the bridge acts on its rising edge
//   link_dat_o  serial config data to the bridge
//   link_load_o load strobe to the bridge
//   link_dat_i  serial result data from the bridge
module adc_link_master #(
  parameter int unsigned DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        cont,
  input  logic [15:0] cfg1_i,
  input  logic [15:0] cfg2_i,
  output logic        busy,
  output logic [15:0] res_o,
  output logic        res_valid,
  output logic        frame_err,
  output logic        link_clk_o,
  output logic        link_dat_o,
  output logic        link_load_o,
  input  logic        link_dat_i
);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

  state_t      state, state_nxt;
  logic [7:0]  div_cnt;
  logic [5:0]  bit_cnt;
  logic [31:0] shadow;
  logic [19:0] samp;

  logic phase_end, rise, fall;

  // link_clk_o is itself the phase flag: a phase ending while it is low is
  // the rising edge, while high it is the end of the whole bit period.
  assign phase_end = (div_cnt == DIV_M1);
  assign rise      = phase_end && !link_clk_o;
  assign fall      = phase_end &&  link_clk_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start || cont)            state_nxt = SHIFT;
      SHIFT:   if (fall && bit_cnt == 6'd31) state_nxt = LOAD;
      LOAD:    if (fall)                     state_nxt = IDLE;
      default:                               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      res_o       <= '0;
      res_valid   <= 1'b0;
      frame_err   <= 1'b0;
      link_clk_o  <= 1'b0;
      link_dat_o  <= 1'b0;
      link_load_o <= 1'b0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      shadow      <= '0;
      samp        <= '0;
    end else begin
      res_valid <= 1'b0;
      if (state == IDLE) begin
        if (state_nxt == SHIFT) begin
          shadow     <= {cfg2_i, cfg1_i};
          busy       <= 1'b1;
          link_clk_o <= 1'b0;
          link_dat_o <= cfg1_i[0];
          div_cnt    <= '0;
          bit_cnt    <= '0;
        end
      end else begin
        if (phase_end) begin
          div_cnt    <= '0;
          link_clk_o <= ~link_clk_o;
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end

        // Only the first 20 bits carry the frame; the tail is don't-care.
        if (rise && bit_cnt < 6'd20) samp[bit_cnt[4:0]] <= link_dat_i;

        if (fall) begin
          if (state == LOAD) begin
            busy        <= 1'b0;
            link_load_o <= 1'b0;
            bit_cnt     <= '0;
            res_valid   <= 1'b1;
            res_o       <= samp[17:2];
            frame_err   <= !(samp[0] && !samp[1] && !samp[18] && samp[19]);
          end else if (bit_cnt == 6'd31) begin
            link_load_o <= 1'b1;
            link_dat_o  <= 1'b0;
            bit_cnt     <= 6'd32;
          end else begin
            bit_cnt    <= bit_cnt + 6'd1;
            link_dat_o <= shadow[bit_cnt[4:0] + 5'd1];
          end
        end
      end
    end
  end

endmodule
